// File: rtl/dmem_ctrl.sv
// dmem_ctrl: round-robin per-lane LSU data-memory responder with fixed latency.
// Define DMEM_PERF_CNT_EN to build the read/write completion counters.
module dmem_ctrl #(
    parameter int NUM_LANES   = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 7,
    parameter int MEM_LATENCY = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_LANES-1:0]             mem_read_valid,
    input  logic [NUM_LANES-1:0]             mem_write_valid,
    input  logic [NUM_LANES*ADDR_WIDTH-1:0]  mem_addr,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]  mem_write_data,
    output logic [NUM_LANES-1:0]             mem_read_ack,
    output logic [NUM_LANES-1:0]             mem_write_ack,
    output logic [NUM_LANES*DATA_WIDTH-1:0]  mem_read_data,
    output logic [31:0]                      read_count,
    output logic [31:0]                      write_count
);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY    = 2'd1;
    localparam logic [1:0] RESPOND = 2'd2;

    logic [1:0]                  state;
    logic [CW-1:0]               cnt;
    logic [LW-1:0]               rr_ptr;
    logic [LW-1:0]               lane_q;
    logic                        op_wr_q;
    logic [ADDR_WIDTH-1:0]       addr_q;
    logic [DATA_WIDTH-1:0]       data_q;
    logic [NUM_LANES-1:0]        read_mask;
    logic [NUM_LANES-1:0]        write_mask;
    logic [NUM_LANES-1:0]        rd_elig;
    logic [NUM_LANES-1:0]        wr_elig;
    logic                        found;
    logic [LW-1:0]               gnt_lane;
    logic                        gnt_write;
    logic                        access;

    logic [DATA_WIDTH-1:0]       mem [2**ADDR_WIDTH];

    assign rd_elig = mem_read_valid & ~read_mask;
    assign wr_elig = mem_write_valid & ~write_mask;
    assign access  = (state == BUSY) && (cnt == CW'(MEM_LATENCY - 1));

    // First eligible lane at or above rr_ptr; a pending read beats a write.
    always_comb begin
        int idx;
        idx       = 0;
        found     = 1'b0;
        gnt_lane  = '0;
        gnt_write = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_LANES;
            if (!found && (rd_elig[idx] || wr_elig[idx])) begin
                found     = 1'b1;
                gnt_lane  = LW'(idx);
                gnt_write = !rd_elig[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            rr_ptr        <= '0;
            lane_q        <= '0;
            op_wr_q       <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            read_mask     <= '0;
            write_mask    <= '0;
            mem_read_ack  <= '0;
            mem_write_ack <= '0;
            mem_read_data <= '0;
        end else begin
            read_mask  <= (read_mask | mem_read_ack) & mem_read_valid;
            write_mask <= (write_mask | mem_write_ack) & mem_write_valid;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        lane_q  <= gnt_lane;
                        op_wr_q <= gnt_write;
                        addr_q  <= mem_addr[int'(gnt_lane)*ADDR_WIDTH +: ADDR_WIDTH];
                        data_q  <= mem_write_data[int'(gnt_lane)*DATA_WIDTH +: DATA_WIDTH];
                        cnt     <= '0;
                        rr_ptr  <= LW'((int'(gnt_lane) + 1) % NUM_LANES);
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (access) begin
                        state <= RESPOND;
                        if (op_wr_q) begin
                            mem_write_ack[lane_q] <= 1'b1;
                        end else begin
                            mem_read_ack[lane_q] <= 1'b1;
                            mem_read_data[int'(lane_q)*DATA_WIDTH +: DATA_WIDTH]
                                <= mem[addr_q];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESPOND: begin
                    mem_read_ack  <= '0;
                    mem_write_ack <= '0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array is not reset; reset forces IDLE so an in-flight write never commits.
    always_ff @(posedge clk) begin
        if (access && op_wr_q) begin
            mem[addr_q] <= data_q;
        end
    end

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (access) begin
            if (op_wr_q) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end else begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
        end
    end

    assign read_count  = rd_cnt_q;
    assign write_count = wr_cnt_q;
`else
    assign read_count  = '0;
    assign write_count = '0;
`endif

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory responder that services the per-lane LSU memory handshake for one SIMD core. Each lane presents a read or write request (valid, address, write data). The block arbitrates round-robin among lanes and performs one access at a time against an internal word array with fixed latency. It returns a one-cycle read/write acknowledge and a per-lane held read-data word.

## Interface
Parameters:
- NUM_LANES, 4, number of LSU lanes served
- DATA_WIDTH, 64, word width
- ADDR_WIDTH, 7, word address width; array depth is 2^ADDR_WIDTH
- MEM_LATENCY, 2, edges from grant to acknowledge (legal range ≥1)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- mem_read_valid  in  NUM_LANES  per-lane read request
- mem_write_valid  in  NUM_LANES  per-lane write request
- mem_addr  in  NUM_LANES*ADDR_WIDTH  lane i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- mem_write_data  in  NUM_LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- mem_read_ack  out  NUM_LANES  one-cycle read-done pulse per lane
- mem_write_ack  out  NUM_LANES  one-cycle write-done pulse per lane
- mem_read_data  out  NUM_LANES*DATA_WIDTH  per-lane read result, held between reads
- read_count  out  32  completed reads (see Configuration)
- write_count  out  32  completed writes (see Configuration)

## Operation
- Reset values: all acks 0, mem_read_data 0, counters 0, FSM IDLE, rr_ptr 0, all masks clear. The memory array is not reset.
- Eligibility:
  - A lane is eligible for read when mem_read_valid[i]=1 and read_mask[i]=0.
  - A lane is eligible for write when mem_write_valid[i]=1 and write_mask[i]=0.
  - A lane is eligible if either condition holds.
- Masks:
  - read_mask[i] (write_mask[i]) is set when the lane's read (write) is acknowledged.
  - It clears on any edge where the matching valid is sampled 0.
  - This lets a requester hold valid after ack without a duplicate access.
- FSM:
  - IDLE:
    - The first eligible lane searching upward from rr_ptr (wrapping) is granted.
    - On grant, the block latches lane index, op, address and write data, sets cnt=0 and goes to BUSY.
    - rr_ptr becomes (granted+1) mod NUM_LANES.
    - With no eligible lane, it stays IDLE.
  - BUSY:
    - If cnt==MEM_LATENCY-1, it goes to RESPOND and performs the access on this edge.
    - Otherwise cnt increments.
  - RESPOND: all acks clear, set the mask, go to IDLE.
- Access on the BUSY→RESPOND edge:
  - Write: array[addr] <= data; mem_write_ack[lane] <= 1.
  - Read: mem_read_data[lane] <= array[addr]; mem_read_ack[lane] <= 1.
- MEM_LATENCY=1: BUSY lasts one edge.
- Same lane with read and write both eligible: the read is granted first. The write stays pending and is arbitrated later as a separate transaction.
- Other lanes' mem_read_data never change on an access.
- Requests that drop valid before grant are simply not serviced. Inputs are sampled only at grant.

## Timing
- Grant edge E0; ack high from edge E0+MEM_LATENCY to E0+MEM_LATENCY+1 (exactly one cycle); earliest next grant at E0+MEM_LATENCY+2.
- Throughput: one access per MEM_LATENCY+2 cycles.
- A write committed at edge E is visible to any read granted at or after E+1.
- At most one bit across both ack vectors is high in any cycle.
- Reset asserted mid-transaction:
  - Acks drop immediately and the in-flight access is abandoned.
  - A write not yet committed is not performed.
  - After release the FSM starts in IDLE with rr_ptr=0.

## Configuration
- DMEM_PERF_CNT_EN defined:
  - read_count and write_count increment (wrapping at 2^32) on each read/write ack edge.
  - Both are cleared by reset.
- Undefined: no counter logic is built; read_count and write_count are tied to 0.

## Test plan
- Reset check: drive rst=0 mid-BUSY → all acks and read data 0 immediately. After release, a write from lane 0 is granted first and takes 4 cycles.
- Single write then read: lane 1 writes 0xDEAD_BEEF_0000_0001 to addr 5. Ack goes high exactly at grant+2 for one cycle. Lane 1 then reads addr 5 → mem_read_data lane 1 = 0xDEAD_BEEF_0000_0001, other lanes' data unchanged.
- Round-robin fairness: all 4 lanes read simultaneously and hold valid until ack → acks in lane order 0,1,2,3, spaced 4 cycles apart. A repeat burst starting with rr_ptr=2 serves 2,3,0,1.
- Held valid after ack: lane 2 keeps mem_write_valid=1 for 10 cycles after its ack → exactly one write_ack and one array update. Deassert for one cycle then reassert → a second write.
- Read/write collision on one lane: lane 3 asserts both at addr 9 (old value 7, new 42) → read_ack first with data 7, then write_ack. A subsequent read returns 42.
- With DMEM_PERF_CNT_EN: 3 writes and 5 reads → write_count=3, read_count=5. Without the macro, both stay 0.
